// File: rtl/stack_lifo_if.sv
// ============================================================================
// Module : stack_lifo_if
// Bus between the stack processor and the hardware LIFO data stack.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface stack_lifo_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, data_in,
        input  data_out, full, empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, full, empty, count, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/stack_lifo.sv
// ============================================================================
// Module : stack_lifo
// LIFO data stack with registered pop data and atomic push+pop replace-top.
// Optional sticky error flags enabled by macro STACK_ERR_FLAGS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stack_lifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  wire logic   clk,
    input  wire logic   resetN,
    stack_lifo_if.slave bus
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0]   sp_q, sp_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              full, empty;
    logic [ADDR_W:0]   sp_m1;
    logic [ADDR_W-1:0] top_idx, free_idx, wr_idx;
    logic              mem_we;

    assign full     = (sp_q == C_DEPTH);
    assign empty    = (sp_q == '0);
    assign sp_m1    = sp_q - 1'b1;
    assign top_idx  = sp_m1[ADDR_W-1:0];
    assign free_idx = sp_q[ADDR_W-1:0];

    always_comb begin
        sp_d       = sp_q;
        data_out_d = data_out_q;
        mem_we     = 1'b0;
        wr_idx     = free_idx;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (!full) begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    data_out_d = mem_q[top_idx];
                    sp_d       = sp_m1;
                end
            end
            2'b11: begin
                // Replace-top when occupied; pass straight through when empty.
                if (!empty) begin
                    data_out_d = mem_q[top_idx];
                    mem_we     = 1'b1;
                    wr_idx     = top_idx;
                end else begin
                    data_out_d = bus.data_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            sp_q       <= '0;
            data_out_q <= '0;
        end else begin
            sp_q       <= sp_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage carries no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (resetN && mem_we)
            mem_q[wr_idx] <= bus.data_in;
    end

`ifdef STACK_ERR_FLAGS_EN
    logic overflow_q, underflow_q;
    logic ovf_evt, unf_evt;

    assign ovf_evt = bus.push & ~bus.pop & full;
    assign unf_evt = bus.pop & ~bus.push & empty;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | ovf_evt;
            underflow_q <= underflow_q | unf_evt;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.data_out = data_out_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = sp_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_lifo.sv
// ============================================================================
// Module : tb_stack_lifo
// Directed and randomized checks of stack_lifo against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stack_lifo;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

`ifdef STACK_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    stack_lifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    stack_lifo #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf, m_unf;
    bit               m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!resetN) begin
            m_q.delete();
            m_dout  = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (bus.push && !bus.pop) begin
                if (m_q.size() < DEPTH) m_q.push_back(bus.data_in);
                else                    m_ovf = 1'b1;
            end else if (bus.pop && !bus.push) begin
                if (m_q.size() > 0) m_dout = m_q.pop_back();
                else                m_unf  = 1'b1;
            end else if (bus.pop && bus.push) begin
                if (m_q.size() > 0) begin
                    m_dout = m_q[m_q.size()-1];
                    m_q[m_q.size()-1] = bus.data_in;
                end else begin
                    m_dout = bus.data_in;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("count",     32'(bus.count),    32'(m_q.size()));
            chk("full",      32'(bus.full),     32'(m_q.size() == DEPTH));
            chk("empty",     32'(bus.empty),    32'(m_q.size() == 0));
            chk("data_out",  32'(bus.data_out), 32'(m_dout));
            chk("overflow",  32'(bus.overflow), 32'(FLAGS & m_ovf));
            chk("underflow", 32'(bus.underflow),32'(FLAGS & m_unf));
        end
    end

    task automatic op(input bit p, input bit q, input logic [WIDTH-1:0] d);
        @(negedge clk);
        resetN      = 1'b1;
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_op(input bit p);
        @(negedge clk);
        resetN      = 1'b0;
        bus.push    = p;
        bus.pop     = 1'b0;
        bus.data_in = 8'h5A;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
        rst_op(1'b0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_dout",  32'(bus.data_out), 32'd0);

        op(1, 0, 8'h11); op(1, 0, 8'h22); op(1, 0, 8'h33);
        chk("three_count", 32'(bus.count), 32'd3);
        chk("three_empty", 32'(bus.empty), 32'd0);
        op(0, 1, 8'h00); chk("pop1", 32'(bus.data_out), 32'h33);
        op(0, 1, 8'h00); chk("pop2", 32'(bus.data_out), 32'h22);
        op(0, 1, 8'h00); chk("pop3", 32'(bus.data_out), 32'h11);
        chk("pop_empty", 32'(bus.empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) op(1, 0, 8'(i));
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        op(1, 0, 8'hAA);
        chk("ovf_count", 32'(bus.count),    32'd16);
        chk("ovf_flag",  32'(bus.overflow), 32'(FLAGS));
        op(0, 1, 8'h00);
        chk("ovf_pop", 32'(bus.data_out), 32'h0F);

        rst_op(1'b0);
        op(1, 1, 8'h3C);
        chk("bypass_dout",  32'(bus.data_out), 32'h3C);
        chk("bypass_count", 32'(bus.count),    32'd0);
        chk("bypass_ovf",   32'(bus.overflow), 32'd0);
        chk("bypass_unf",   32'(bus.underflow),32'd0);
        op(0, 1, 8'h00);
        chk("unf_hold",  32'(bus.data_out), 32'h3C);
        chk("unf_count", 32'(bus.count),    32'd0);
        chk("unf_flag",  32'(bus.underflow),32'(FLAGS));

        rst_op(1'b0);
        op(1, 0, 8'h05); op(1, 0, 8'h06);
        op(1, 1, 8'h77);
        chk("rep_dout",  32'(bus.data_out), 32'h06);
        chk("rep_count", 32'(bus.count),    32'd2);
        op(0, 1, 8'h00);
        chk("rep_pop", 32'(bus.data_out), 32'h77);

        rst_op(1'b0);
        for (int i = 0; i < DEPTH; i++) op(1, 0, 8'(8'h40 + i));
        op(1, 0, 8'hEE);
        for (int i = 0; i < DEPTH - 5; i++) op(0, 1, 8'h00);
        chk("pre_count", 32'(bus.count),    32'd5);
        chk("pre_ovf",   32'(bus.overflow), 32'(FLAGS));
        rst_op(1'b1);
        chk("rstp_count", 32'(bus.count),    32'd0);
        chk("rstp_empty", 32'(bus.empty),    32'd1);
        chk("rstp_dout",  32'(bus.data_out), 32'd0);
        chk("rstp_ovf",   32'(bus.overflow), 32'd0);
        op(0, 0, 8'h00);
        chk("rstp_discard", 32'(bus.count), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0)       rst_op(1'($urandom_range(0, 1)));
            else if (r < 40)  op(1, 0, 8'($urandom));
            else if (r < 75)  op(0, 1, 8'($urandom));
            else if (r < 90)  op(1, 1, 8'($urandom));
            else              op(0, 0, 8'($urandom));
        end

        op(0, 0, 8'h00);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
